registro_banco_acum: RTL
========================

Name: registro_banco_acum

Overview:
- Parametrised successor to the single 8-bit enable register.
- Holds DEPTH words of W bits with per-word valid flags.
- Supports several modes on each word: hold, indexed load, indexed accumulate (saturating or wrapping), whole-bank shift chain and synchronous clear.
- Used in the hypercube matrix-multiply datapath for partial-sum storage and for moving operands between nodes.

Parameters:
W, 8, word width in bits (>= 2)
DEPTH, 4, number of words (>= 2, need not be a power of two)
SAT, 1, 1 = accumulate saturates at 2^W-1; 0 = accumulate wraps modulo 2^W
AW, clog2(DEPTH), select width (derived; not overridden)

Ports:
CLK  input  1  master clock, rising edge
RST_N  input  1  master reset, asynchronous, active-low
EN  input  1  enable; 0 forces hold regardless of MODE
MODE  input  3  operation code (see Behaviour)
SEL  input  AW  word index for load/accumulate/read
D  input  W  data in
Q  output  W  word[SEL] (registered contents, combinational mux)
Q_LAST  output  W  word[DEPTH-1] (shift-chain tail)
VALID  output  DEPTH  per-word valid flags
OVF  output  1  sticky accumulate-overflow flag

Behaviour:
- One clock domain, CLK rising edge.
- Reset: RST_N low asynchronously clears all words, VALID and OVF to 0, and holds them at 0 while low. Release is sampled at the next CLK edge. Reset mid-operation discards any pending operation.
- All state updates on the CLK rising edge, only when EN=1. When EN=0 every word, VALID and OVF hold.
- MODE 000, hold: no change.
- MODE 001, load: word[SEL] <= D; VALID[SEL] <= 1.
- MODE 010, accumulate: word[SEL] <= word[SEL] + D, computed at W+1 bits.
  - On carry out with SAT=1, result = 2^W-1.
  - On carry out with SAT=0, result = low W bits.
  - Carry out in either case sets OVF <= 1.
  - VALID[SEL] <= 1.
- MODE 011, shift:
  - word[0] <= D; word[i] <= word[i-1] for i = 1..DEPTH-1.
  - VALID[0] <= 1; VALID[i] <= VALID[i-1].
  - Word DEPTH-1's old value is dropped and was visible on Q_LAST before the edge.
- MODE 100, clear: all words <= 0; VALID <= 0; OVF <= 0.
- MODE 101, clear flag: OVF <= 0 only.
- MODE 110, 111: reserved, behave as hold.
- SEL >= DEPTH: load and accumulate are ignored (no word, VALID or OVF change) and Q reads 0. Shift and clear are unaffected by SEL.
- OVF is sticky: stays 1 until MODE 100, MODE 101 or reset. It is not cleared by later non-overflowing accumulates.
- Read latency:
  - Q and Q_LAST reflect register contents with zero added latency.
  - A write at edge n is visible on Q from edge n onward (new value after the edge).
  - Q changes combinationally with SEL.
- Accumulate is unsigned arithmetic. D is not sign-extended.
- No read-during-write bypass: in the cycle before the edge, Q shows the old value.

Test Plan:
1. Reset: drive RST_N low mid-cycle after loading 0x5A into word 2 -> Q=0, VALID=0000, OVF=0 immediately, before any CLK edge; all stay 0 while RST_N is low.
2. Load/hold: EN=1, MODE=001, SEL=1, D=0x3C, then EN=0 with MODE=001, D=0xFF for 3 cycles -> Q(SEL=1)=0x3C throughout; VALID=0010.
3. Accumulate saturate (SAT=1): load word0=0xF0, then accumulate D=0x20 -> word0=0xFF, OVF=1. Then MODE=101 -> OVF=0 and word0 stays 0xFF.
4. Accumulate wrap (SAT=0): word0=0xF0, accumulate D=0x20 -> word0=0x10, OVF=1. Then accumulate D=0x01 -> word0=0x11, OVF stays 1.
5. Shift chain (DEPTH=4): from reset, shift D=0x11, 0x22, 0x33, 0x44 -> Q_LAST=0x11 and VALID=1111 after the 4th edge. A 5th shift with D=0x55 -> Q_LAST=0x22, word0=0x55.
6. Out-of-range and clear (DEPTH=3, AW=2): load with SEL=3, D=0x77 -> no state change, Q=0. Then MODE=100 after filling all words -> all words 0, VALID=000, OVF=0.

Source files
------------

// File: rtl/registro_banco_acum.sv
// ---------------------------------------------------------------------------
// registro_banco_acum
//    Bank of DEPTH words, W bits each, with a valid flag per word and a
//    sticky accumulate-overflow flag. This is the partial-sum and operand
//    store of the hypercube matrix-multiply datapath. It is the parametrised
//    successor of the old single 8-bit enable register.
//
//    Operations, selected by MODE and applied only when EN=1:
//       000 hold | 001 load | 010 accumulate | 011 shift chain
//       100 clear bank | 101 clear OVF | 110/111 reserved (hold)
//
// Parameters
//    W      word width in bits (>= 2)
//    DEPTH  number of words (>= 2; need not be a power of two)
//    SAT    1 = accumulate saturates at 2^W-1, 0 = accumulate wraps
//    AW     select width, derived from DEPTH
//
// Ports
//    CLK     in   master clock, rising edge
//    RST_N   in   asynchronous active-low reset; clears words, VALID and OVF
//    EN      in   update enable; 0 holds all state regardless of MODE
//    MODE    in   operation code
//    SEL     in   word index for load, accumulate and read
//    D       in   data in
//    Q       out  word[SEL], or 0 when SEL >= DEPTH (combinational read)
//    Q_LAST  out  word[DEPTH-1], the tail of the shift chain
//    VALID   out  per-word valid flags
//    OVF     out  sticky accumulate-overflow flag
// ---------------------------------------------------------------------------
module registro_banco_acum #(
   parameter int  W     = 8,
   parameter int  DEPTH = 4,
   parameter bit  SAT   = 1'b1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic [2:0]       MODE,
   input  logic [AW-1:0]    SEL,
   input  logic [W-1:0]     D,
   output logic [W-1:0]     Q,
   output logic [W-1:0]     Q_LAST,
   output logic [DEPTH-1:0] VALID,
   output logic             OVF
);

   typedef enum logic [2:0] {
      MODE_HOLD     = 3'b000,
      MODE_LOAD     = 3'b001,
      MODE_ACC      = 3'b010,
      MODE_SHIFT    = 3'b011,
      MODE_CLEAR    = 3'b100,
      MODE_CLR_FLAG = 3'b101,
      MODE_RSV6     = 3'b110,
      MODE_RSV7     = 3'b111
   } mode_t;

   mode_t            mode;
   logic [W-1:0]     word_r   [DEPTH];
   logic [W-1:0]     word_nxt [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [DEPTH-1:0] valid_nxt;
   logic             ovf_r;
   logic             ovf_nxt;
   logic             sel_ok;
   logic [W-1:0]     word_sel;
   logic [W:0]       acc_sum;
   logic             acc_carry;
   logic [W-1:0]     acc_res;

   assign mode = mode_t'(MODE);

   // When DEPTH fills the whole select space, every SEL value is a real
   // word. In that case the range compare would be against a wrapped
   // constant, so it is replaced by a constant 1.
   generate
      if (DEPTH == (1 << AW)) begin : g_sel_full
         assign sel_ok = 1'b1;
      end else begin : g_sel_part
         assign sel_ok = (SEL < AW'(DEPTH));
      end
   endgenerate

   // Read mux. An out-of-range SEL matches no word and reads 0.
   always_comb begin
      word_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (SEL == AW'(i)) begin
            word_sel = word_r[i];
         end
      end
   end

   // Unsigned add with one extra bit so that the carry out is visible.
   assign acc_sum   = {1'b0, word_sel} + {1'b0, D};
   assign acc_carry = acc_sum[W];
   assign acc_res   = (acc_carry && SAT) ? {W{1'b1}} : acc_sum[W-1:0];

   always_comb begin
      word_nxt  = word_r;
      valid_nxt = valid_r;
      ovf_nxt   = ovf_r;
      case (mode)
         MODE_LOAD: begin
            if (sel_ok) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (SEL == AW'(i)) begin
                     word_nxt[i]  = D;
                     valid_nxt[i] = 1'b1;
                  end
               end
            end
         end
         MODE_ACC: begin
            if (sel_ok) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (SEL == AW'(i)) begin
                     word_nxt[i]  = acc_res;
                     valid_nxt[i] = 1'b1;
                  end
               end
               // OVF is sticky; a carry-free accumulate leaves it untouched.
               if (acc_carry) begin
                  ovf_nxt = 1'b1;
               end
            end
         end
         MODE_SHIFT: begin
            word_nxt[0] = D;
            for (int i = 1; i < DEPTH; i++) begin
               word_nxt[i] = word_r[i-1];
            end
            valid_nxt = {valid_r[DEPTH-2:0], 1'b1};
         end
         MODE_CLEAR: begin
            for (int i = 0; i < DEPTH; i++) begin
               word_nxt[i] = '0;
            end
            valid_nxt = '0;
            ovf_nxt   = 1'b0;
         end
         MODE_CLR_FLAG: begin
            ovf_nxt = 1'b0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_r[i] <= '0;
         end
         valid_r <= '0;
         ovf_r   <= 1'b0;
      end else if (EN) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_r[i] <= word_nxt[i];
         end
         valid_r <= valid_nxt;
         ovf_r   <= ovf_nxt;
      end
   end

   assign Q      = word_sel;
   assign Q_LAST = word_r[DEPTH-1];
   assign VALID  = valid_r;
   assign OVF    = ovf_r;

endmodule
